// File: rtl/lcd_ctrl_pkg.sv
// Shared enums and elaboration helpers for the windowed LCD controller.
package lcd_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_LOAD     = 3'd0,
    CMD_ZOOM_IN  = 3'd1,
    CMD_ZOOM_FIT = 3'd2,
    CMD_RIGHT    = 3'd3,
    CMD_LEFT     = 3'd4,
    CMD_UP       = 3'd5,
    CMD_DOWN     = 3'd6,
    CMD_MIRROR   = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    STREAM = 2'd3
  } state_e;

  typedef enum logic {
    FIT  = 1'b0,
    ZOOM = 1'b1
  } mode_e;

  // Centred window origin along one image axis.
  function automatic int default_origin(input int img_len, input int win);
    return (img_len - win + 1) / 2;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_win_addr_gen.sv
// Window raster walker: maps window (i,j) to an image row/col for fit or zoom view.
// Mirror column reversal is present only when LCD_CTRL_MIRROR_EN is defined.
module lcd_win_addr_gen
  import lcd_ctrl_pkg::*;
#(
  parameter int IMG_W  = 12,
  parameter int IMG_H  = 9,
  parameter int WIN    = 4,
  parameter int FIT_R0 = 1,
  parameter int FIT_C0 = 1,
  parameter int FIT_SR = 2,
  parameter int FIT_SC = 3,
  parameter int RW     = idx_w(IMG_H),
  parameter int CW     = idx_w(IMG_W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          step,
  input  logic          mode,
  input  logic [RW-1:0] orow,
  input  logic [CW-1:0] ocol,
`ifdef LCD_CTRL_MIRROR_EN
  input  logic          mirror,
`endif
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam int WW = idx_w(WIN);
  localparam logic [WW-1:0] WMAX = WW'(WIN - 1);

  logic [WW-1:0] wi;
  logic [WW-1:0] wj;
  logic [WW-1:0] wj_eff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wi <= '0;
      wj <= '0;
    end else if (clear) begin
      wi <= '0;
      wj <= '0;
    end else if (step) begin
      if (wj == WMAX) begin
        wj <= '0;
        wi <= wi + WW'(1);
      end else begin
        wj <= wj + WW'(1);
      end
    end
  end

`ifdef LCD_CTRL_MIRROR_EN
  assign wj_eff = mirror ? (WMAX - wj) : wj;
`else
  assign wj_eff = wj;
`endif

  always_comb begin
    row = '0;
    col = '0;
    if (mode_e'(mode) == ZOOM) begin
      row = orow + RW'(wi);
      col = ocol + CW'(wj_eff);
    end else begin
      row = RW'(FIT_R0) + RW'(wi) * RW'(FIT_SR);
      col = CW'(FIT_C0) + CW'(wj_eff) * CW'(FIT_SC);
    end
  end

  assign last = (wi == WMAX) && (wj == WMAX);

endmodule

// File: rtl/lcd_ctrl_win.sv
// Windowed LCD controller: image RAM, command FSM and valid/ready output stream.
// Optional mirror command (code 7) is built only with LCD_CTRL_MIRROR_EN defined.
//
//   state  | meaning
//   IDLE   | waiting for a command, busy=0
//   LOAD   | writing IMG_W*IMG_H pixels from datain, row-major
//   SHIFT  | one cycle moving the zoom origin (clamped)
//   STREAM | emitting WIN*WIN pixels under out_ready back-pressure
module lcd_ctrl_win
  import lcd_ctrl_pkg::*;
#(
  parameter int DW     = 8,
  parameter int IMG_W  = 12,
  parameter int IMG_H  = 9,
  parameter int WIN    = 4,
  parameter int FIT_R0 = 1,
  parameter int FIT_C0 = 1,
  parameter int FIT_SR = 2,
  parameter int FIT_SC = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] datain,
  input  logic          out_ready,
  output logic [DW-1:0] dataout,
  output logic          output_valid,
  output logic          busy
);

  localparam int RW    = idx_w(IMG_H);
  localparam int CW    = idx_w(IMG_W);
  localparam int PIX_N = IMG_W * IMG_H;
  localparam int AW    = idx_w(PIX_N);

  localparam logic [RW-1:0] OR0      = RW'(default_origin(IMG_H, WIN));
  localparam logic [CW-1:0] OC0      = CW'(default_origin(IMG_W, WIN));
  localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - WIN);
  localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - WIN);
  localparam logic [AW-1:0] LOAD_TOP = AW'(PIX_N - 1);

  if ((FIT_R0 + (WIN - 1) * FIT_SR >= IMG_H) || (FIT_C0 + (WIN - 1) * FIT_SC >= IMG_W) ||
      (WIN > IMG_H) || (WIN > IMG_W)) begin : g_bad_params
    $error("lcd_ctrl_win: fit sampling or window exceeds image bounds");
  end

  state_e        state, state_nxt;
  mode_e         mode, mode_nxt;
  cmd_e          shift_cmd, shift_cmd_nxt;
  logic [RW-1:0] orow, orow_nxt;
  logic [CW-1:0] ocol, ocol_nxt;
  logic [AW-1:0] load_left, load_left_nxt;
  logic          busy_nxt, valid_nxt;
  logic          last_q, last_nxt;
  logic [DW-1:0] dout_nxt;
  logic          ag_clear, ag_step, ag_last, ram_we;
  logic [RW-1:0] ag_row;
  logic [CW-1:0] ag_col;
  logic [AW-1:0] rd_addr, wr_addr;
`ifdef LCD_CTRL_MIRROR_EN
  logic          mirror, mirror_nxt;
`endif

  logic [DW-1:0] mem [PIX_N];

  lcd_win_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .WIN   (WIN),
    .FIT_R0(FIT_R0),
    .FIT_C0(FIT_C0),
    .FIT_SR(FIT_SR),
    .FIT_SC(FIT_SC),
    .RW    (RW),
    .CW    (CW)
  ) u_addr (
    .clk   (clk),
    .reset (reset),
    .clear (ag_clear),
    .step  (ag_step),
    .mode  (mode),
    .orow  (orow),
    .ocol  (ocol),
`ifdef LCD_CTRL_MIRROR_EN
    .mirror(mirror),
`endif
    .row   (ag_row),
    .col   (ag_col),
    .last  (ag_last)
  );

  assign rd_addr = AW'(ag_row) * AW'(IMG_W) + AW'(ag_col);
  // load_left counts down, so the write address is its complement from the top.
  assign wr_addr = LOAD_TOP - load_left;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[wr_addr] <= datain;
    end
  end

  always_comb begin
    state_nxt     = state;
    mode_nxt      = mode;
    shift_cmd_nxt = shift_cmd;
    orow_nxt      = orow;
    ocol_nxt      = ocol;
    load_left_nxt = load_left;
    busy_nxt      = busy;
    valid_nxt     = output_valid;
    last_nxt      = last_q;
    dout_nxt      = dataout;
    ag_clear      = 1'b0;
    ag_step       = 1'b0;
    ram_we        = 1'b0;
`ifdef LCD_CTRL_MIRROR_EN
    mirror_nxt    = mirror;
`endif

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_e'(cmd))
            CMD_LOAD: begin
              state_nxt     = LOAD;
              busy_nxt      = 1'b1;
              ag_clear      = 1'b1;
              load_left_nxt = LOAD_TOP;
            end
            CMD_ZOOM_FIT: begin
              mode_nxt  = FIT;
              orow_nxt  = OR0;
              ocol_nxt  = OC0;
              state_nxt = STREAM;
              busy_nxt  = 1'b1;
              ag_clear  = 1'b1;
            end
            CMD_ZOOM_IN: begin
              if (mode == FIT) begin
                mode_nxt = ZOOM;
                orow_nxt = OR0;
                ocol_nxt = OC0;
              end
              state_nxt = STREAM;
              busy_nxt  = 1'b1;
              ag_clear  = 1'b1;
            end
            CMD_RIGHT, CMD_LEFT, CMD_UP, CMD_DOWN: begin
              shift_cmd_nxt = cmd_e'(cmd);
              state_nxt     = (mode == ZOOM) ? SHIFT : STREAM;
              busy_nxt      = 1'b1;
              ag_clear      = 1'b1;
            end
`ifdef LCD_CTRL_MIRROR_EN
            CMD_MIRROR: begin
              mirror_nxt = ~mirror;
              state_nxt  = STREAM;
              busy_nxt   = 1'b1;
              ag_clear   = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end

      LOAD: begin
        ram_we = 1'b1;
        if (load_left == '0) begin
          mode_nxt  = FIT;
          orow_nxt  = OR0;
          ocol_nxt  = OC0;
          state_nxt = STREAM;
          ag_clear  = 1'b1;
`ifdef LCD_CTRL_MIRROR_EN
          mirror_nxt = 1'b0;
`endif
        end else begin
          load_left_nxt = load_left - AW'(1);
        end
      end

      SHIFT: begin
        case (shift_cmd)
          CMD_RIGHT: if (ocol != COL_MAX) ocol_nxt = ocol + CW'(1);
          CMD_LEFT:  if (ocol != '0)      ocol_nxt = ocol - CW'(1);
          CMD_UP:    if (orow != '0)      orow_nxt = orow - RW'(1);
          CMD_DOWN:  if (orow != ROW_MAX) orow_nxt = orow + RW'(1);
          default: ;
        endcase
        state_nxt = STREAM;
      end

      STREAM: begin
        // Register slot advances when empty (first pixel) or on a transfer.
        if (!output_valid || out_ready) begin
          if (output_valid && last_q) begin
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            last_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            dout_nxt  = mem[rd_addr];
            valid_nxt = 1'b1;
            last_nxt  = ag_last;
            ag_step   = !ag_last;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      mode         <= FIT;
      shift_cmd    <= CMD_LOAD;
      orow         <= OR0;
      ocol         <= OC0;
      load_left    <= '0;
      busy         <= 1'b0;
      output_valid <= 1'b0;
      last_q       <= 1'b0;
      dataout      <= '0;
`ifdef LCD_CTRL_MIRROR_EN
      mirror       <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      mode         <= mode_nxt;
      shift_cmd    <= shift_cmd_nxt;
      orow         <= orow_nxt;
      ocol         <= ocol_nxt;
      load_left    <= load_left_nxt;
      busy         <= busy_nxt;
      output_valid <= valid_nxt;
      last_q       <= last_nxt;
      dataout      <= dout_nxt;
`ifdef LCD_CTRL_MIRROR_EN
      mirror       <= mirror_nxt;
`endif
    end
  end

endmodule

// File: doc/lcd_ctrl_win.md
Name: lcd_ctrl_win

Overview:
- Parametrised successor of the team's fixed 12x9 LCD controller.
- Buffers one IMG_W x IMG_H greyscale image loaded serially from datain.
- Streams a WIN x WIN window: either a decimated "fit" view or a 1:1 "zoom" view with a movable origin.
- Adds `out_ready` output back-pressure, clamped shifts, and an optional mirror mode.

Parameters:
- DW, 8, pixel width in bits.
- IMG_W, 12, image columns.
- IMG_H, 9, image rows.
- WIN, 4, output window edge; WIN*WIN pixels per frame.
- FIT_R0, 1, first sampled row in fit view.
- FIT_C0, 1, first sampled column in fit view.
- FIT_SR, 2, row stride in fit view.
- FIT_SC, 3, column stride in fit view.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- cmd  in  3  command code
- cmd_valid  in  1  command strobe; sampled only when busy=0
- datain  in  DW  image pixel, row-major, during load
- out_ready  in  1  sink accepts dataout this cycle
- dataout  out  DW  pixel
- output_valid  out  1  dataout valid
- busy  out  1  command in progress; cmd_valid ignored while high

Behaviour:
- Reset (reset=0, async): busy=0, output_valid=0, dataout=0.
  - Internal state: state=IDLE, mode=FIT, origin=(OR0,OC0), mirror=0.
  - OR0=(IMG_H-WIN+1)/2 and OC0=(IMG_W-WIN+1)/2; defaults give (3,4).
  - Image RAM contents are not reset.
- Command acceptance: a command is accepted on a clock edge where busy=0 and cmd_valid=1; busy rises on the same edge.
  - Codes: 0 LOAD, 1 ZOOM_IN, 2 ZOOM_FIT, 3 RIGHT, 4 LEFT, 5 UP, 6 DOWN, 7 MIRROR (optional).
  - Unsupported codes are dropped and busy stays 0.
- States: IDLE, LOAD, SHIFT, STREAM.
- LOAD:
  - datain is sampled on each of the IMG_W*IMG_H cycles following acceptance, column index fastest.
  - Sets mode=FIT and origin=(OR0,OC0), then enters STREAM for the fit view.
  - No stall is possible during LOAD.
- ZOOM_FIT: mode=FIT, origin reset to default, then STREAM.
- ZOOM_IN:
  - From FIT: mode=ZOOM with origin=(OR0,OC0).
  - From ZOOM: origin unchanged.
  - Then STREAM.
- Shift commands, mode=FIT: no origin change; re-stream the fit view.
- Shift commands, mode=ZOOM:
  - One SHIFT cycle moves the origin by 1, then STREAM.
  - Bounds: col in 0..IMG_W-WIN, row in 0..IMG_H-WIN.
  - At a bound the origin is held (clamped) and the unchanged window is still streamed.
- STREAM:
  - Emits WIN*WIN pixels in raster order: window row outer, column inner.
  - FIT pixel (i,j) = img[FIT_R0+i*FIT_SR][FIT_C0+j*FIT_SC].
  - ZOOM pixel (i,j) = img[orow+i][ocol+j].
  - First output_valid=1 appears on the cycle after STREAM entry.
  - A pixel transfers on an edge with output_valid&&out_ready. While out_ready=0, dataout and output_valid hold stable.
  - After the WIN*WIN-th transfer: output_valid=0, busy=0, state=IDLE, all on the same edge.
- Latency with out_ready held at 1:
  - Display commands: 16 pixels on consecutive cycles; busy is high for 17 cycles (zoom/fit) or 18 cycles (shift in ZOOM).
  - LOAD: busy is high for 108+17 cycles.
- Address arithmetic:
  - Row and column counters are $clog2-sized.
  - Fit indices are computed with multiplication by constants; no wrap occurs for legal parameters.
  - Elaboration-time check: FIT_R0+(WIN-1)*FIT_SR < IMG_H, FIT_C0+(WIN-1)*FIT_SC < IMG_W, and WIN <= IMG_H, WIN <= IMG_W.
- Display command before any LOAD: the stream completes normally; data values are don't-care.
- Reset asserted mid-LOAD or mid-STREAM: outputs drop immediately; the partial image is retained but undefined.

Optional Feature:
- Macro: LCD_CTRL_MIRROR_EN.
- Defined:
  - cmd 7 toggles the mirror flag, then streams the current view (fit or zoom).
  - With mirror=1, window column j is read from window column WIN-1-j.
  - LOAD clears mirror.
- Undefined: cmd 7 is unsupported (dropped, busy stays 0) and there is no mirror logic.

Decomposition:
- Package lcd_ctrl_pkg:
  - cmd_e enum for codes 0-7.
  - state_e enum (IDLE/LOAD/SHIFT/STREAM).
  - mode_e enum (FIT/ZOOM).
  - Helper function for default origin computation.
- One sub-module, lcd_win_addr_gen:
  - Inputs: mode, origin, mirror, step/clear.
  - Outputs: the image row/col address and a last-pixel flag.
  - Top level keeps the RAM, FSM and handshake.

Test Plan:
- LOAD with pixel=row*16+col, out_ready=1 -> after 108 datain cycles, 16 outputs: 0x11,0x14,0x17,0x1A,0x31,...,0x7A; busy falls the cycle after the last output.
- ZOOM_IN after load -> window at (3,4): first 0x34, last 0x67; then UP x4 -> origins row 2,1,0,0 (the fourth UP is clamped, window still streamed).
- ZOOM mode, RIGHT x5 from col 4 -> col reaches 8 and stays at 8; window first pixel 0x38.
- Shift in FIT mode -> fit view re-streamed, origin unchanged; a following ZOOM_IN starts at (3,4).
- out_ready toggled 1,0,0,1 pattern during STREAM -> no pixel lost or duplicated, dataout stable while stalled; cmd_valid pulsed while busy is ignored.
- Reset pulled low mid-STREAM -> output_valid=0 and busy=0 immediately; with LCD_CTRL_MIRROR_EN, cmd 7 in ZOOM at (3,4) yields first pixel 0x37.
